// File: rtl/hook_ctrl.sv
// Hook motion controller (cast/drop/hold/reel, one move per frame_tick) and hook/line pixel generator.
// Pixel outputs lag x/y by one clk to line up with the sprite ROM's registered read.
module hook_ctrl #(
    parameter logic [9:0]  X_POS     = 10'd312,
    parameter logic [9:0]  Y_TOP     = 10'd40,
    parameter logic [9:0]  Y_MAX     = 10'd440,
    parameter logic [9:0]  DROP_STEP = 10'd2,
    parameter logic [9:0]  REEL_STEP = 10'd1,
    parameter logic [9:0]  LINE_COL  = 10'd5,
    parameter logic [9:0]  LINE_TOP  = 10'd0,
    parameter logic [11:0] TRANSP    = 12'h0F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        btn_cast,
    input  logic        btn_reel,
    input  logic        catch,
    output logic [3:0]  rom_row,
    output logic [3:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic        hook_on,
    output logic [11:0] hook_rgb,
    output logic [9:0]  hook_y,
    output logic [1:0]  state,
    output logic        hooked,
    output logic        landed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2,
        REEL = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] hook_y_q, hook_y_d;
    logic       hooked_q, hooked_d;
    logic       landed_q, landed_d;
    logic       cast_prev_q;
    logic       cast_edge;
    logic [9:0] drop_sum;
    logic [9:0] reel_diff;

    assign cast_edge = btn_cast & ~cast_prev_q;
    assign drop_sum  = hook_y_q + DROP_STEP;
    assign reel_diff = hook_y_q - REEL_STEP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hook_y_q    <= Y_TOP;
            hooked_q    <= 1'b0;
            landed_q    <= 1'b0;
            cast_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hook_y_q    <= hook_y_d;
            hooked_q    <= hooked_d;
            landed_q    <= landed_d;
            cast_prev_q <= btn_cast;
        end
    end

    // A catch or reel request in the same cycle as frame_tick takes precedence over the move.
    always_comb begin
        state_d  = state_q;
        hook_y_d = hook_y_q;
        hooked_d = hooked_q;
        landed_d = 1'b0;
        case (state_q)
            IDLE: begin
                hook_y_d = Y_TOP;
                if (cast_edge) state_d = DROP;
            end
            DROP: begin
                if (catch) begin
                    hooked_d = 1'b1;
                    state_d  = REEL;
                end else if (btn_reel) begin
                    state_d = REEL;
                end else if (frame_tick) begin
                    if (drop_sum >= Y_MAX) begin
                        hook_y_d = Y_MAX;
                        state_d  = HOLD;
                    end else begin
                        hook_y_d = drop_sum;
                    end
                end
            end
            HOLD: begin
                if (catch) begin
                    hooked_d = 1'b1;
                    state_d  = REEL;
                end else if (btn_reel) begin
                    state_d = REEL;
                end
            end
            REEL: begin
                if (frame_tick) begin
                    if (reel_diff <= Y_TOP) begin
                        hook_y_d = Y_TOP;
                        state_d  = IDLE;
                        landed_d = hooked_q;
                        hooked_d = 1'b0;
                    end else begin
                        hook_y_d = reel_diff;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hook_y = hook_y_q;
    assign state  = state_q;
    assign hooked = hooked_q;
    assign landed = landed_q;

    logic [9:0] x_end, y_end, line_x;
    logic       in_box, line_on, y_ge_top;

    assign x_end  = X_POS + 10'd16;
    assign y_end  = hook_y_q + 10'd12;
    assign line_x = X_POS + LINE_COL;

    assign in_box  = (x >= X_POS) & (x < x_end) & (y >= hook_y_q) & (y < y_end);
    assign rom_row = 4'(y - hook_y_q);
    assign rom_col = 4'(x - X_POS);

    generate
        if (LINE_TOP == 10'd0) begin : g_line_top0
            assign y_ge_top = 1'b1;
        end else begin : g_line_topn
            assign y_ge_top = (y >= LINE_TOP);
        end
    endgenerate

    assign line_on = (x == line_x) & y_ge_top & (y < hook_y_q);

    logic in_box_q, line_on_q, video_on_q;
    logic spr_px;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_q   <= 1'b0;
            line_on_q  <= 1'b0;
            video_on_q <= 1'b0;
        end else begin
            in_box_q   <= in_box;
            line_on_q  <= line_on;
            video_on_q <= video_on;
        end
    end

    // Sprite wins over the line; colour is forced to 0 whenever the pixel is not shown.
    assign spr_px  = in_box_q & (rom_color != TRANSP);
    assign hook_on = video_on_q & (spr_px | line_on_q);

    always_comb begin
        hook_rgb = 12'h000;
        if (video_on_q) begin
            if (spr_px)         hook_rgb = rom_color;
            else if (line_on_q) hook_rgb = 12'hFFF;
        end
    end

endmodule

// File: tb/tb_hook_ctrl.sv
// Randomized bench for hook_ctrl: reference model feeds an expectation queue, a monitor pops and compares each cycle.
module tb_hook_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        frame_tick = 1'b0;
    logic        btn_cast = 1'b0;
    logic        btn_reel = 1'b0;
    logic        catch_s = 1'b0;
    logic [3:0]  rom_row, rom_col;
    logic [11:0] rom_color = '0;
    logic        hook_on;
    logic [11:0] hook_rgb;
    logic [9:0]  hook_y;
    logic [1:0]  state;
    logic        hooked, landed;

    always #5 clk = ~clk;

    hook_ctrl dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
        .frame_tick(frame_tick), .btn_cast(btn_cast), .btn_reel(btn_reel),
        .catch(catch_s), .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
        .hook_on(hook_on), .hook_rgb(hook_rgb), .hook_y(hook_y), .state(state),
        .hooked(hooked), .landed(landed)
    );

    // Sprite ROM with one-cycle read latency
    logic [11:0] rom_mem [0:255];
    always @(posedge clk) rom_color <= rom_mem[{rom_row, rom_col}];

    typedef struct packed {
        logic        on;
        logic [11:0] rgb;
        logic [1:0]  st;
        logic [9:0]  hy;
        logic        hk;
        logic        ld;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 drop, 2 hold, 3 reel
    int m_state = 0;
    int m_y = 40;
    bit m_hooked = 0;
    bit m_prev = 0;

    always @(posedge clk) begin : model
        exp_t e;
        int xi, yi, ny, col;
        bit inbox, line, spr, on, ld;
        e = '0;
        if (reset) begin
            m_state = 0; m_y = 40; m_hooked = 0; m_prev = 0;
            e.hy = 10'd40;
        end else begin
            xi = int'(x); yi = int'(y);
            inbox = (xi >= 312) && (xi < 328) && (yi >= m_y) && (yi < m_y + 12);
            line  = (xi == 317) && (yi >= 0) && (yi < m_y);
            col   = int'(rom_mem[((yi - m_y) % 16) * 16 + (xi - 312) % 16]);
            if (!inbox) col = 0;
            spr = inbox && (col != 12'h0F0);
            on  = video_on && (spr || line);
            e.on  = on;
            e.rgb = !on ? 12'h000 : (spr ? 12'(col) : 12'hFFF);
            ld = 0;
            case (m_state)
                0: if (btn_cast && !m_prev) m_state = 1;
                1: begin
                    if (catch_s) begin m_hooked = 1; m_state = 3; end
                    else if (btn_reel) m_state = 3;
                    else if (frame_tick) begin
                        ny = m_y + 2;
                        if (ny >= 440) begin m_y = 440; m_state = 2; end
                        else m_y = ny;
                    end
                end
                2: begin
                    if (catch_s) begin m_hooked = 1; m_state = 3; end
                    else if (btn_reel) m_state = 3;
                end
                default: if (frame_tick) begin
                    ny = m_y - 1;
                    if (ny <= 40) begin
                        m_y = 40; m_state = 0; ld = m_hooked; m_hooked = 0;
                    end else m_y = ny;
                end
            endcase
            m_prev = btn_cast;
            e.st = 2'(m_state); e.hy = 10'(m_y); e.hk = m_hooked; e.ld = ld;
        end
        q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e, g;
        #1;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
            e = q.pop_front();
            g = {hook_on, hook_rgb, state, hook_y, hooked, landed};
            if (g !== e) begin
                failures++;
                $display("FAIL cycle t=%0t got on=%0b rgb=%h st=%0d y=%0d hk=%0b ld=%0b required on=%0b rgb=%h st=%0d y=%0d hk=%0b ld=%0b",
                         $time, g.on, g.rgb, g.st, g.hy, g.hk, g.ld, e.on, e.rgb, e.st, e.hy, e.hk, e.ld);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", nm, got, req);
        end
    endtask

    bit rand_xy = 1;
    logic [9:0] px = '0, py = '0;
    logic pv = 1'b0;

    task automatic step(input bit tick, input bit cast, input bit reel, input bit ctch);
        int lo;
        @(negedge clk);
        frame_tick = tick; btn_cast = cast; btn_reel = reel; catch_s = ctch;
        if (rand_xy) begin
            lo = (m_y > 4) ? m_y - 4 : 0;
            x = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(305, 332)) : 10'($urandom_range(0, 639));
            y = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(lo, m_y + 15)) : 10'($urandom_range(0, 479));
            video_on = ($urandom_range(0, 7) != 0);
        end else begin
            x = px; y = py; video_on = pv;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom_mem[i] = ($urandom_range(0, 2) == 0) ? 12'h0F0 : 12'($urandom);

        // Reset held while frame_tick toggles
        for (int i = 0; i < 6; i++) step(i % 2 == 0, 0, 0, 0);
        settle();
        chk("reset_state", int'(state), 0);
        chk("reset_hook_y", int'(hook_y), 40);
        chk("reset_hook_on", int'(hook_on), 0);
        @(negedge clk); reset = 1'b0;
        ticks(10);
        settle();
        chk("idle_no_cast_y", int'(hook_y), 40);

        // Full drop to the bottom
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        ticks(199);
        settle();
        chk("drop_199_state", int'(state), 1);
        chk("drop_199_y", int'(hook_y), 438);
        ticks(1);
        settle();
        chk("drop_bottom_y", int'(hook_y), 440);
        chk("drop_bottom_state", int'(state), 2);
        ticks(1);
        settle();
        chk("hold_frozen_y", int'(hook_y), 440);

        // Reel from HOLD without a fish
        step(0, 0, 1, 0);
        settle();
        chk("hold_reel_state", int'(state), 3);
        ticks(400);
        settle();
        chk("reel_home_state", int'(state), 0);
        chk("reel_home_landed", int'(landed), 0);

        // Catch mid-drop, coinciding with frame_tick
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        ticks(50);
        settle();
        chk("cast50_y", int'(hook_y), 140);
        step(1, 0, 0, 1);
        settle();
        chk("catch_state", int'(state), 3);
        chk("catch_y", int'(hook_y), 140);
        chk("catch_hooked", int'(hooked), 1);
        ticks(99);
        step(1, 0, 0, 0);
        settle();
        chk("land_pulse", int'(landed), 1);
        chk("land_state", int'(state), 0);
        step(0, 0, 0, 0);
        settle();
        chk("land_pulse_end", int'(landed), 0);
        chk("land_hooked_clr", int'(hooked), 0);

        // Pixel path at hook_y=40
        rand_xy = 0; px = 10'd317; py = 10'd42; pv = 1'b1;
        rom_mem[8'h25] = 12'hFFF;
        step(0, 0, 0, 0);
        #1;
        chk("rom_row", int'(rom_row), 2);
        chk("rom_col", int'(rom_col), 5);
        settle();
        chk("pix_on", int'(hook_on), 1);
        chk("pix_rgb", int'(hook_rgb), 12'hFFF);
        rom_mem[8'h25] = 12'h0F0;
        step(0, 0, 0, 0);
        settle();
        chk("pix_transp_on", int'(hook_on), 0);
        chk("pix_transp_rgb", int'(hook_rgb), 0);
        rom_mem[8'h25] = 12'hFFF;
        py = 10'd52;
        step(0, 0, 0, 0);
        settle();
        chk("pix_row12_on", int'(hook_on), 0);

        // Fishing line at hook_y=100, then blanking
        rand_xy = 1;
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        ticks(30);
        settle();
        chk("line_setup_y", int'(hook_y), 100);
        rand_xy = 0; px = 10'd317; py = 10'd60; pv = 1'b1;
        step(0, 0, 0, 0);
        settle();
        chk("line_on", int'(hook_on), 1);
        chk("line_rgb", int'(hook_rgb), 12'hFFF);
        pv = 1'b0;
        step(0, 0, 0, 0);
        settle();
        chk("line_blank_on", int'(hook_on), 0);
        chk("line_blank_rgb", int'(hook_rgb), 0);
        rand_xy = 1;
        step(0, 0, 1, 0);
        ticks(60);

        // Randomized traffic, including resets mid-flight
        for (int i = 0; i < 4000; i++) begin
            bit c;
            c = ($urandom_range(0, 19) == 0) ? ~btn_cast : btn_cast;
            step($urandom_range(0, 3) == 0, c, $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0);
            if ($urandom_range(0, 499) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
